matrix_ram_loader: RTL and testbench

MATRIX_RAM_LOADER -- requirements
Module: matrix_ram_loader

---
 rtl/matrix_ram_loader.sv | 120 ++++++++++++
 tb/tb_matrix_ram_loader.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/matrix_ram_loader.sv
// rtl/matrix_ram_loader.sv - streams a 5x5 matrix into RAM as the 5x10 augmented matrix [A|I]
module matrix_ram_loader #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 6,
  parameter int BASE_ADDR = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t              state_q, state_d;
  logic [2:0]          row_q, row_d;
  logic [3:0]          col_q, col_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_din_q, ram_din_d;
  logic                done_q, done_d;

  logic                wr_en;
  logic [ADDR_W-1:0]   elem_addr;
  logic [DATA_W-1:0]   elem_data;

  // Streamed columns accept data; identity columns are generated locally, so the stream is held off.
  always_comb begin
    s_ready = (state_q == LOAD) && (col_q < 4'd5);
  end

  // Element address/value for the current row/col; address wraps modulo 2^ADDR_W.
  always_comb begin
    elem_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(row_q) * ADDR_W'(10) + ADDR_W'(col_q);
    if (col_q < 4'd5) begin
      elem_data = s_data;
    end else if ((col_q - 4'd5) == {1'b0, row_q}) begin
      elem_data = DATA_W'(1);
    end else begin
      elem_data = '0;
    end
  end

  // Next-state logic: counter advance on each element written, wrap to next row after col 9.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    wr_en   = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          row_d   = 3'd0;
          col_d   = 4'd0;
        end
      end
      LOAD: begin
        wr_en = (col_q < 4'd5) ? s_valid : 1'b1;
        if (wr_en) begin
          if (col_q == 4'd9) begin
            col_d = 4'd0;
            if (row_q == 3'd4) begin
              state_d = DONE;
              row_d   = 3'd0;
            end else begin
              row_d = row_q + 3'd1;
            end
          end else begin
            col_d = col_q + 4'd1;
          end
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    ram_we_d   = wr_en;
    ram_addr_d = wr_en ? elem_addr : ram_addr_q;
    ram_din_d  = wr_en ? elem_data : ram_din_q;
  end

  // State, counters and registered RAM port / done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      row_q      <= 3'd0;
      col_q      <= 4'd0;
      ram_we_q   <= 1'b0;
      ram_addr_q <= '0;
      ram_din_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      ram_we_q   <= ram_we_d;
      ram_addr_q <= ram_addr_d;
      ram_din_q  <= ram_din_d;
      done_q     <= done_d;
    end
  end

  assign ram_we   = ram_we_q;
  assign ram_addr = ram_addr_q;
  assign ram_din  = ram_din_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;

endmodule

// File: tb/tb_matrix_ram_loader.sv
// tb/tb_matrix_ram_loader.sv - self-checking bench for matrix_ram_loader
module tb_matrix_ram_loader;

  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 6;
  localparam int BASE_ADDR = 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic              busy;
  logic              done;

  matrix_ram_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cnt = 0;
  int done_cyc = -1;
  int consumed = 0;
  logic [DATA_W-1:0] vals [25];
  int wr_addr [$];
  logic [DATA_W-1:0] wr_data [$];
  int wr_cyc [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ram_we) begin
      wr_addr.push_back(int'(ram_addr));
      wr_data.push_back(ram_din);
      wr_cyc.push_back(cyc - start_cyc);
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc - start_cyc;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_s_ready"}, 64'(s_ready), 64'd0);
    chk({tag, "_ram_we"}, 64'(ram_we), 64'd0);
    chk({tag, "_ram_addr"}, 64'(ram_addr), 64'd0);
    chk({tag, "_ram_din"}, 64'(ram_din), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
  endtask

  // Reference image of [A|I]: row-major stream on the left, identity on the right.
  task automatic check_image(input string tag);
    int n;
    logic [DATA_W-1:0] exp_v;
    n = wr_addr.size();
    chk({tag, "_nwrites"}, 64'(n), 64'd50);
    if (n > 50) n = 50;
    for (int i = 0; i < n; i++) begin
      int r, c;
      r = i / 10;
      c = i % 10;
      if (c < 5) exp_v = vals[r * 5 + c];
      else       exp_v = (c - 5 == r) ? DATA_W'(1) : DATA_W'(0);
      chk($sformatf("%s_addr%0d", tag, i), 64'(wr_addr[i]), 64'((BASE_ADDR + 10 * r + c) % (1 << ADDR_W)));
      chk($sformatf("%s_data%0d", tag, i), 64'(wr_data[i]), 64'(exp_v));
    end
    chk({tag, "_consumed"}, 64'(consumed), 64'd25);
    chk({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      start   = 1'b0;
      s_valid = 1'(($urandom % 2));
      s_data  = $urandom();
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
  endtask

  // mode 0: continuous valid, 1: valid every other cycle, 2: random valid.
  task automatic run_load(input int mode, input int restart_at, input int reset_at);
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    done_cnt = 0;
    done_cyc = -1;
    consumed = 0;
    s_valid  = 1'b0;
    start    = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 1; t < 300 && done_cnt == 0; t++) begin
      start = (t == restart_at);
      rst_n = (t != reset_at);
      case (mode)
        0:       s_valid = 1'b1;
        1:       s_valid = (t % 2 == 0);
        default: s_valid = ($urandom_range(0, 3) != 0);
      endcase
      s_data = (consumed < 25) ? vals[consumed] : $urandom();
      @(negedge clk);
      if (s_valid && s_ready && rst_n) consumed = consumed + 1;
      @(posedge clk); #1;
      if (t == reset_at) break;
    end
    start   = 1'b0;
    s_valid = 1'b0;
    rst_n   = 1'b1;
  endtask

  initial begin
    int nw;
    rst_n = 1'b0; start = 1'b1; s_valid = 1'b1; s_data = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("start_in_reset_busy", 64'(busy), 64'd0);

    // Valid held in IDLE without start must not be consumed.
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1;
      s_data  = $urandom();
      @(negedge clk);
      chk($sformatf("idle_s_ready%0d", i), 64'(s_ready), 64'd0);
      chk($sformatf("idle_ram_we%0d", i), 64'(ram_we), 64'd0);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;

    // Sequential stream with continuous valid: image and latency.
    for (int i = 0; i < 25; i++) vals[i] = DATA_W'(i + 1);
    run_load(0, -1, -1);
    idle_cycles(10);
    check_image("seq");
    chk("seq_first_wr_cyc", 64'(wr_cyc.size() > 0 ? wr_cyc[0] : -1), 64'd2);
    chk("seq_last_wr_cyc", 64'(wr_cyc.size() > 0 ? wr_cyc[wr_cyc.size() - 1] : -1), 64'd51);
    chk("seq_done_cyc", 64'(done_cyc), 64'd52);
    chk("seq_busy_after", 64'(busy), 64'd0);

    // Same stream, valid every other cycle.
    run_load(1, -1, -1);
    idle_cycles(10);
    check_image("stall");

    // Start pulsed mid-load is ignored.
    run_load(0, 20, -1);
    idle_cycles(10);
    check_image("restart");

    // Random data including extremes, random valid.
    for (int i = 0; i < 25; i++) vals[i] = $urandom();
    vals[0]  = 32'hFFFF_FFFF;
    vals[12] = 32'h8000_0000;
    vals[24] = 32'h7FFF_FFFF;
    run_load(2, -1, -1);
    idle_cycles(10);
    check_image("rand");

    // Reset mid-load abandons it.
    run_load(0, -1, 30);
    chk_outputs_zero("midrst");
    nw = wr_addr.size();
    idle_cycles(15);
    chk("midrst_no_more_writes", 64'(wr_addr.size()), 64'(nw));
    chk("midrst_no_done", 64'(done_cnt), 64'd0);
    chk("midrst_first_addr", 64'(nw > 0 ? wr_addr[0] : -1), 64'(BASE_ADDR));

    // Fresh load after the abandoned one rewrites from the start.
    for (int i = 0; i < 25; i++) vals[i] = $urandom();
    run_load(2, -1, -1);
    idle_cycles(10);
    check_image("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
